// File: rtl/exception_sequencer.sv
// -----------------------------------------------------------------------------
// exception_sequencer
//
// Purpose:
//   Multi-cycle controller driven by the memory-stage exception decode. For a
//   regular exception it flushes and stalls the pipeline, then writes EPC,
//   Cause and Status (EXL set) to CP0 through its dedicated write port, and
//   finally redirects fetch to EXC_VECTOR. For ERET it flushes, writes Status
//   with EXL cleared and redirects fetch to the current EPC. This block is the
//   only agent that performs exception-driven CP0 writes.
//
// Parameters:
//   DATA_WIDTH    width of PC, CP0 data and vector (default 32)
//   EXC_VECTOR    handler entry for every non-ERET exception
//   FLUSH_CYCLES  cycles flush is held before the first CP0 write (1..15)
//
// Ports:
//   clk                in   clock
//   rst_n              in   synchronous, active-low reset
//   exc_valid          in   exception present (sampled only while idle)
//   exc_code           in   MIPS ExcCode, ignored when exc_eret=1
//   exc_eret           in   ERET request, qualified by exc_valid
//   exc_pc             in   PC of the faulting instruction
//   exc_in_delay_slot  in   faulting instruction sits in a branch delay slot
//                           (present only when EXC_SEQ_BD_EN is defined)
//   cp0_status         in   current CP0 Status
//   cp0_epc            in   current CP0 EPC
//   busy               out  sequencer not idle
//   flush              out  kill all in-flight instructions
//   stall              out  freeze PC and IF/ID
//   cp0_we             out  CP0 write strobe, one cycle per write state
//   cp0_waddr          out  CP0 register: 12 Status, 13 Cause, 14 EPC
//   cp0_wdata          out  CP0 write data
//   redirect_valid     out  one-cycle PC load
//   redirect_pc        out  new PC
//
// Build option:
//   EXC_SEQ_BD_EN  when defined, adds exc_in_delay_slot. A latched 1 makes the
//                  EPC write exc_pc-4 and sets Cause.BD (bit 31).
//
// Timing:
//   All outputs are registers loaded from the next state, so they line up
//   exactly with the state they describe. Consequently cp0_status (for the
//   Status write) and cp0_epc (for the ERET redirect) are captured on the edge
//   that enters W_STATUS / REDIRECT respectively.
// -----------------------------------------------------------------------------
module exception_sequencer #(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
   parameter int                    FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_code,
   input  logic                  exc_eret,
   input  logic [DATA_WIDTH-1:0] exc_pc,
`ifdef EXC_SEQ_BD_EN
   input  logic                  exc_in_delay_slot,
`endif
   input  logic [DATA_WIDTH-1:0] cp0_status,
   input  logic [DATA_WIDTH-1:0] cp0_epc,
   output logic                  busy,
   output logic                  flush,
   output logic                  stall,
   output logic                  cp0_we,
   output logic [4:0]            cp0_waddr,
   output logic [DATA_WIDTH-1:0] cp0_wdata,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc
);

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;
   localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FLUSH    = 3'd1,
      S_W_EPC    = 3'd2,
      S_W_CAUSE  = 3'd3,
      S_W_STATUS = 3'd4,
      S_REDIRECT = 3'd5
   } state_t;

   state_t state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;

   // Exception context captured when a sequence starts.
   logic                  take_exc;
   logic [4:0]            code_reg;
   logic                  eret_reg;
   logic [DATA_WIDTH-1:0] pc_reg;
   logic                  bd_reg;

   // Registered outputs and their next values.
   logic                  busy_reg, busy_next;
   logic                  flush_reg, flush_next;
   logic                  stall_reg, stall_next;
   logic                  we_reg, we_next;
   logic [4:0]            waddr_reg, waddr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  rv_reg, rv_next;
   logic [DATA_WIDTH-1:0] rpc_reg, rpc_next;

   // Values written to CP0, derived from the latched context.
   logic [DATA_WIDTH-1:0] epc_value;
   logic [DATA_WIDTH-1:0] cause_value;
   logic [DATA_WIDTH-1:0] status_value;

   assign take_exc = (state_reg == S_IDLE) && exc_valid;

`ifndef EXC_SEQ_BD_EN
   assign bd_reg = 1'b0;
`endif

   // A delay-slot fault must resume at the branch, one word earlier.
   assign epc_value = bd_reg ? (pc_reg - DATA_WIDTH'(4)) : pc_reg;

   always_comb begin
      cause_value      = '0;
      cause_value[6:2] = code_reg;
      cause_value[31]  = bd_reg;
   end

   // EXL (bit 1) is set on entry to the handler and cleared on ERET. A set
   // EXL on a new exception is not treated specially.
   always_comb begin
      status_value = cp0_status;
      status_value[1] = ~eret_reg;
   end

   // ---------------------------------------------------------------------
   // State register, context latches and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         code_reg  <= '0;
         eret_reg  <= 1'b0;
         pc_reg    <= '0;
`ifdef EXC_SEQ_BD_EN
         bd_reg    <= 1'b0;
`endif
         busy_reg  <= 1'b0;
         flush_reg <= 1'b0;
         stall_reg <= 1'b0;
         we_reg    <= 1'b0;
         waddr_reg <= '0;
         wdata_reg <= '0;
         rv_reg    <= 1'b0;
         rpc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (take_exc) begin
            // ERET wins over any code presented alongside it.
            code_reg <= exc_eret ? 5'd0 : exc_code;
            eret_reg <= exc_eret;
            pc_reg   <= exc_pc;
`ifdef EXC_SEQ_BD_EN
            bd_reg   <= exc_in_delay_slot & ~exc_eret;
`endif
         end
         busy_reg  <= busy_next;
         flush_reg <= flush_next;
         stall_reg <= stall_next;
         we_reg    <= we_next;
         waddr_reg <= waddr_next;
         wdata_reg <= wdata_next;
         rv_reg    <= rv_next;
         rpc_reg   <= rpc_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            // exc_valid is only looked at here; requests arriving while a
            // sequence runs belong to instructions that are being flushed.
            if (exc_valid) begin
               state_next = S_FLUSH;
               cnt_next   = FLUSH_LOAD;
            end
         end
         S_FLUSH: begin
            if (cnt_reg == 4'd0) begin
               state_next = eret_reg ? S_W_STATUS : S_W_EPC;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_W_EPC:    state_next = S_W_CAUSE;
         S_W_CAUSE:  state_next = S_W_STATUS;
         S_W_STATUS: state_next = S_REDIRECT;
         S_REDIRECT: state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic: computed from the next state so the registered outputs
   // are valid in the same cycle as the state they belong to.
   // ---------------------------------------------------------------------
   always_comb begin
      busy_next  = (state_next != S_IDLE);
      flush_next = (state_next != S_IDLE);
      stall_next = (state_next != S_IDLE);
      we_next    = 1'b0;
      waddr_next = '0;
      wdata_next = '0;
      rv_next    = 1'b0;
      rpc_next   = '0;
      case (state_next)
         S_W_EPC: begin
            we_next    = 1'b1;
            waddr_next = ADDR_EPC;
            wdata_next = epc_value;
         end
         S_W_CAUSE: begin
            we_next    = 1'b1;
            waddr_next = ADDR_CAUSE;
            wdata_next = cause_value;
         end
         S_W_STATUS: begin
            we_next    = 1'b1;
            waddr_next = ADDR_STATUS;
            wdata_next = status_value;
         end
         S_REDIRECT: begin
            rv_next  = 1'b1;
            rpc_next = eret_reg ? cp0_epc : EXC_VECTOR;
         end
         default: begin
         end
      endcase
   end

   assign busy           = busy_reg;
   assign flush          = flush_reg;
   assign stall          = stall_reg;
   assign cp0_we         = we_reg;
   assign cp0_waddr      = waddr_reg;
   assign cp0_wdata      = wdata_reg;
   assign redirect_valid = rv_reg;
   assign redirect_pc    = rpc_reg;

endmodule
